serial_subtractor_clk: RTL
==========================

Name: serial_subtractor_clk

Overview:
Multi-cycle registered subtractor that computes {bout, diff} = a - b - bin. It processes CHUNK bits per clock, LSB chunk first, with a rippled borrow. It is the inverse-operation companion to the team's registered adder micro-benchmark and is used as a sequential FPGA-flow benchmark. It has a valid/ready handshake on both the input side and the output side.

Parameters:
SIZE, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits subtracted per clock cycle; 1 <= CHUNK <= SIZE.
N (localparam), SIZE/CHUNK, number of BUSY cycles per operation.

Ports:
clk_in  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands a, b, bin are presented.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  SIZE  minuend.
b  input  SIZE  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  diff/bout hold a completed result.
out_ready  input  1  consumer takes the result.
diff  output  SIZE  registered difference, (a - b - bin) mod 2^SIZE.
bout  output  1  registered borrow-out; 1 iff a < b + bin (unsigned).

Interface (already decided): reset rst, synchronous, active-high; clock clk_in.

Behaviour:
- Reset (rst=1 at an edge), which overrides everything else:
  - state = IDLE; diff = 0; bout = 0; out_valid = 0.
  - Chunk index = 0; internal borrow = 0; operand registers = 0.
  - in_ready = 1 in the cycle after reset.
- States are IDLE, BUSY and DONE. in_ready = (state == IDLE); out_valid = (state == DONE), registered.
- IDLE:
  - On an edge with in_valid=1, latch a, b, bin into internal registers.
  - Set borrow = bin, index = 0, go to BUSY.
  - diff/bout keep their previous values until overwritten by the new operation.
- BUSY, chunk k = index:
  - Compute {nb, d} = a[k*CHUNK +: CHUNK] - b[k*CHUNK +: CHUNK] - borrow, with nb = 1 on underflow.
  - Write d into diff[k*CHUNK +: CHUNK]; borrow = nb; index = index + 1.
  - On the last chunk (index == N-1): bout = nb, go to DONE.
- Latency:
  - out_valid rises exactly N edges after the accepting edge (4 with the defaults).
  - Minimum period between accepts is N+2 cycles.
- DONE:
  - diff, bout and out_valid are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE; out_valid is low the next cycle.
  - A new operand is not accepted on that same edge.
- in_valid is ignored in BUSY and DONE; operands may change freely during BUSY without affecting the result.
- out_ready is ignored outside DONE.
- Arithmetic is unsigned modulo 2^SIZE.
  - Borrow ripples through every chunk; a chain that propagates across all chunks (e.g. 0x8000 - 0x7FFF - 1) must resolve correctly.
  - N=1 (CHUNK=SIZE) is legal: a single BUSY cycle.
- Reset mid-operation (BUSY or DONE): the operation is abandoned, with no partial output and out_valid=0 the next cycle.
- rst together with in_valid: reset wins and nothing is accepted.

Test Plan:
1. Defaults. a=0x1234, b=0x0234, bin=0, in_valid pulse in IDLE -> in_ready low for 5 cycles; out_valid high exactly 4 edges after accept; diff=0x1000, bout=0.
2. Wrap. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Then a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, bout=0 (borrow ripples through all 4 chunks).
3. Backpressure. Result 0x00FF-0x000F (bin=0) with out_ready=0 for 5 cycles and in_valid pulsed meanwhile -> out_valid, diff=0x00F0, bout=0 stable; no new accept; out_ready=1 -> out_valid low next cycle, in_ready high.
4. Reset mid-op. Assert rst on the 2nd BUSY cycle -> next cycle out_valid=0, diff=0, bout=0, in_ready=1. Then a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0.
5. Streaming. in_valid and out_ready held at 1 with random operands -> one accept every 6 cycles; every result matches the reference model (a-b-bin) mod 2^16 with the correct bout.
6. Parameter sweep. SIZE=8 with CHUNK=1, 2 and 8, exhaustive a, b, bin -> all results match the model; out_valid latency = 8, 4 and 1 edges respectively.

Source files
------------

// File: rtl/serial_subtractor_clk.sv
// Multi-cycle registered subtractor: {bout, diff} = a - b - bin, CHUNK bits per
// clock with a rippled borrow, valid/ready handshake on both sides.
module serial_subtractor_clk #(
  parameter int SIZE  = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] diff,
  output logic            bout
);

  localparam int N    = SIZE / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [SIZE-1:0]   a_r;
  logic [SIZE-1:0]   b_r;
  logic              borrow_r;
  logic [IDXW-1:0]   idx_r;

  int                base_s;
  logic [CHUNK-1:0]  d_chunk_s;
  logic              nb_s;

  // One chunk of unsigned subtraction; the extra MSB is the borrow-out.
  function automatic logic [CHUNK:0] sub_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             bw
  );
    sub_chunk = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bw};
  endfunction

  // Subtract the chunk currently selected by the index.
  always_comb begin
    base_s              = int'(idx_r) * CHUNK;
    {nb_s, d_chunk_s}   = sub_chunk(a_r[base_s +: CHUNK], b_r[base_s +: CHUNK], borrow_r);
  end

  // Handshake FSM, operand latch, borrow ripple and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= {SIZE{1'b0}};
      b_r       <= {SIZE{1'b0}};
      borrow_r  <= 1'b0;
      idx_r     <= {IDXW{1'b0}};
      diff      <= {SIZE{1'b0}};
      bout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            idx_r    <= {IDXW{1'b0}};
            in_ready <= 1'b0;
            state_r  <= BUSY;
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          // diff is overwritten chunk by chunk; bits above idx keep the old result.
          diff[base_s +: CHUNK] <= d_chunk_s;
          borrow_r              <= nb_s;
          if (idx_r == IDX_LAST) begin
            bout      <= nb_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
